// File: rtl/cnn_pkg.sv
// Shared types and constants for the CNN frame sequencer: FSM encoding,
// error codes and default per-layer row counts.
package cnn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RUN    = 3'd2,
        ST_ARGMAX = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERROR  = 3'd5
    } state_e;

    localparam logic [1:0] ERR_NONE        = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT     = 2'd1;
    localparam logic [1:0] ERR_EARLY_DENSE = 2'd2;
    localparam logic [1:0] ERR_ROW_OVF     = 2'd3;

    localparam int ROWS1_DEF = 12;
    localparam int ROWS2_DEF = 6;
    localparam int ROWS3_DEF = 3;

    localparam int CLASS_W = 3;

    function automatic logic is_busy(input state_e s);
        return (s == ST_LOAD) || (s == ST_RUN) || (s == ST_ARGMAX);
    endfunction

endpackage

// File: rtl/cnn_argmax.sv
// Combinational argmax over packed signed scores; strict greater-than so
// ties resolve to the lowest class index.
module cnn_argmax
    import cnn_pkg::*;
#(
    parameter int N_CLASS = 7,
    parameter int DW      = 8
) (
    input  logic [N_CLASS*DW-1:0] scores_i,
    output logic [CLASS_W-1:0]    idx_o,
    output logic [N_CLASS-1:0]    onehot_o
);

    logic signed [DW-1:0] best;
    logic signed [DW-1:0] cur;

    always_comb begin
        best  = $signed(scores_i[DW-1:0]);
        cur   = best;
        idx_o = '0;
        for (int k = 1; k < N_CLASS; k++) begin
            cur = $signed(scores_i[k*DW +: DW]);
            if (cur > best) begin
                best  = cur;
                idx_o = CLASS_W'(k);
            end
        end
        onehot_o = '0;
        for (int k = 0; k < N_CLASS; k++) begin
            onehot_o[k] = (idx_o == CLASS_W'(k));
        end
    end

endmodule

// File: rtl/cnn_sequencer.sv
// Frame sequencer for the CNN pipeline: kicks the image loader, tracks pool
// rows per layer, captures dense scores, picks the winning class.
module cnn_sequencer
    import cnn_pkg::*;
#(
    parameter int N_CLASS = 7,
    parameter int DW      = 8,
    parameter int ROWS1   = ROWS1_DEF,
    parameter int ROWS2   = ROWS2_DEF,
    parameter int ROWS3   = ROWS3_DEF,
    parameter int TIMEOUT = 1048576
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [3:0]            sel_i,
    input  logic                  l1_valid_i,
    input  logic                  l2_valid_i,
    input  logic                  l3_valid_i,
    input  logic                  dense_valid_i,
    input  logic [N_CLASS*DW-1:0] dense_data_i,
    output logic                  img_start_o,
    output logic [3:0]            img_sel_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [1:0]            err_code_o,
    output logic [CLASS_W-1:0]    class_o,
    output logic [N_CLASS-1:0]    class_onehot_o,
    output logic [15:0]           frame_cnt_o
);

    localparam int C1W = $clog2(ROWS1 + 1);
    localparam int C2W = $clog2(ROWS2 + 1);
    localparam int C3W = $clog2(ROWS3 + 1);
    localparam int WDW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    state_e                state_q, state_d;
    logic                  start_q;
    logic                  img_start_q, img_start_d;
    logic [3:0]            img_sel_q, img_sel_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [1:0]            err_code_q, err_code_d;
    logic [CLASS_W-1:0]    class_q, class_d;
    logic [N_CLASS-1:0]    onehot_q, onehot_d;
    logic [15:0]           frame_cnt_q, frame_cnt_d;
    logic [C1W-1:0]        cnt1_q, cnt1_d;
    logic [C2W-1:0]        cnt2_q, cnt2_d;
    logic [C3W-1:0]        cnt3_q, cnt3_d;
    logic [WDW-1:0]        wd_q, wd_d;
    logic [N_CLASS*DW-1:0] dense_q, dense_d;

    logic                  start_edge;
    logic                  any_pulse;
    logic                  row_ovf;
    logic                  cnt3_full;
    logic [CLASS_W-1:0]    am_idx;
    logic [N_CLASS-1:0]    am_onehot;

    cnn_argmax #(
        .N_CLASS (N_CLASS),
        .DW      (DW)
    ) u_argmax (
        .scores_i (dense_q),
        .idx_o    (am_idx),
        .onehot_o (am_onehot)
    );

    assign start_edge = start_i & ~start_q;
    assign any_pulse  = l1_valid_i | l2_valid_i | l3_valid_i | dense_valid_i;
    assign cnt3_full  = (cnt3_q == C3W'(ROWS3));
    assign row_ovf    = (l1_valid_i && (cnt1_q == C1W'(ROWS1)))
                     || (l2_valid_i && (cnt2_q == C2W'(ROWS2)))
                     || (l3_valid_i && cnt3_full);

    always_comb begin
        state_d     = state_q;
        img_start_d = 1'b0;
        img_sel_d   = img_sel_q;
        err_code_d  = err_code_q;
        class_d     = class_q;
        onehot_d    = onehot_q;
        frame_cnt_d = frame_cnt_q;
        cnt1_d      = cnt1_q;
        cnt2_d      = cnt2_q;
        cnt3_d      = cnt3_q;
        wd_d        = wd_q;
        dense_d     = dense_q;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start_edge) begin
                    state_d     = ST_LOAD;
                    img_start_d = 1'b1;
                    img_sel_d   = sel_i;
                    err_code_d  = ERR_NONE;
                    class_d     = '0;
                    onehot_d    = '0;
                    cnt1_d      = '0;
                    cnt2_d      = '0;
                    cnt3_d      = '0;
                end
            end
            ST_LOAD: begin
                state_d = ST_RUN;
                wd_d    = '0;
            end
            ST_RUN: begin
                if (l1_valid_i && (cnt1_q != C1W'(ROWS1))) cnt1_d = cnt1_q + C1W'(1);
                if (l2_valid_i && (cnt2_q != C2W'(ROWS2))) cnt2_d = cnt2_q + C2W'(1);
                if (l3_valid_i && !cnt3_full)              cnt3_d = cnt3_q + C3W'(1);
                wd_d = any_pulse ? '0 : wd_q + WDW'(1);
                // Error causes are checked in priority order: overflow, early dense, timeout.
                if (row_ovf) begin
                    state_d    = ST_ERROR;
                    err_code_d = ERR_ROW_OVF;
                end else if (dense_valid_i && !cnt3_full) begin
                    state_d    = ST_ERROR;
                    err_code_d = ERR_EARLY_DENSE;
                end else if (dense_valid_i) begin
                    state_d = ST_ARGMAX;
                    dense_d = dense_data_i;
                end else if (!any_pulse && (wd_q == WDW'(TIMEOUT - 1))) begin
                    state_d    = ST_ERROR;
                    err_code_d = ERR_TIMEOUT;
                end
            end
            ST_ARGMAX: begin
                state_d     = ST_DONE;
                class_d     = am_idx;
                onehot_d    = am_onehot;
                frame_cnt_d = frame_cnt_q + 16'd1;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = is_busy(state_d);
        done_d = (state_d == ST_DONE);
        err_d  = (state_d == ST_ERROR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            start_q     <= 1'b0;
            img_start_q <= 1'b0;
            img_sel_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= ERR_NONE;
            class_q     <= '0;
            onehot_q    <= '0;
            frame_cnt_q <= '0;
            cnt1_q      <= '0;
            cnt2_q      <= '0;
            cnt3_q      <= '0;
            wd_q        <= '0;
            dense_q     <= '0;
        end else begin
            state_q     <= state_d;
            start_q     <= start_i;
            img_start_q <= img_start_d;
            img_sel_q   <= img_sel_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            class_q     <= class_d;
            onehot_q    <= onehot_d;
            frame_cnt_q <= frame_cnt_d;
            cnt1_q      <= cnt1_d;
            cnt2_q      <= cnt2_d;
            cnt3_q      <= cnt3_d;
            wd_q        <= wd_d;
            dense_q     <= dense_d;
        end
    end

    assign img_start_o    = img_start_q;
    assign img_sel_o      = img_sel_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign err_o          = err_q;
    assign err_code_o     = err_code_q;
    assign class_o        = class_q;
    assign class_onehot_o = onehot_q;
    assign frame_cnt_o    = frame_cnt_q;

endmodule

// File: tb/tb_cnn_sequencer.sv
// Self-checking bench for cnn_sequencer: directed frames plus randomized
// legal and faulty frames against a frame-level reference model.
module tb_cnn_sequencer;

    localparam int NC = 7;
    localparam int DWB = 8;
    localparam int TO = 64;

    logic            clk = 1'b0;
    logic            reset;
    logic            start_i;
    logic [3:0]      sel_i;
    logic            l1_valid_i, l2_valid_i, l3_valid_i, dense_valid_i;
    logic [NC*DWB-1:0] dense_data_i;
    logic            img_start_o;
    logic [3:0]      img_sel_o;
    logic            busy_o, done_o, err_o;
    logic [1:0]      err_code_o;
    logic [2:0]      class_o;
    logic [NC-1:0]   class_onehot_o;
    logic [15:0]     frame_cnt_o;

    int n_checks = 0;
    int n_bad = 0;
    int exp_frames = 0;
    logic [2:0] exp_q[$];

    cnn_sequencer #(
        .N_CLASS (NC),
        .DW      (DWB),
        .ROWS1   (12),
        .ROWS2   (6),
        .ROWS3   (3),
        .TIMEOUT (TO)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start_i        (start_i),
        .sel_i          (sel_i),
        .l1_valid_i     (l1_valid_i),
        .l2_valid_i     (l2_valid_i),
        .l3_valid_i     (l3_valid_i),
        .dense_valid_i  (dense_valid_i),
        .dense_data_i   (dense_data_i),
        .img_start_o    (img_start_o),
        .img_sel_o      (img_sel_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .err_o          (err_o),
        .err_code_o     (err_code_o),
        .class_o        (class_o),
        .class_onehot_o (class_onehot_o),
        .frame_cnt_o    (frame_cnt_o)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // reference model: scores packing and argmax
    function automatic logic [NC*DWB-1:0] pack(input int sc[NC]);
        logic [NC*DWB-1:0] v;
        int s;
        v = '0;
        for (int k = 0; k < NC; k++) begin
            s = sc[k];
            v[k*DWB +: DWB] = s[DWB-1:0];
        end
        return v;
    endfunction

    function automatic int ref_argmax(input int sc[NC]);
        int best;
        int idx;
        best = sc[0];
        idx = 0;
        for (int k = 1; k < NC; k++) begin
            if (sc[k] > best) begin
                best = sc[k];
                idx = k;
            end
        end
        return idx;
    endfunction

    // drivers
    task automatic drive(input logic a, input logic b, input logic c, input logic d,
                         input logic [NC*DWB-1:0] data);
        l1_valid_i = a;
        l2_valid_i = b;
        l3_valid_i = c;
        dense_valid_i = d;
        dense_data_i = data;
        tick();
        l1_valid_i = 1'b0;
        l2_valid_i = 1'b0;
        l3_valid_i = 1'b0;
        dense_valid_i = 1'b0;
        dense_data_i = NC*DWB'($urandom);
    endtask

    task automatic do_start(input logic [3:0] sel);
        start_i = 1'b1;
        sel_i = sel;
        tick();
        check_eq("load_img_start", 32'(img_start_o), 1);
        check_eq("load_busy", 32'(busy_o), 1);
        check_eq("load_done", 32'(done_o), 0);
        check_eq("load_err", 32'(err_o), 0);
        check_eq("load_sel", 32'(img_sel_o), 32'(sel));
        check_eq("load_onehot", 32'(class_onehot_o), 0);
        start_i = 1'b0;
        sel_i = 4'($urandom);
        tick();
        check_eq("run_img_start", 32'(img_start_o), 0);
        check_eq("run_busy", 32'(busy_o), 1);
    endtask

    // random interleaving of exactly n1/n2/n3 pool pulses, idle gaps of at most one cycle
    task automatic feed_layers(input int n1, input int n2, input int n3);
        int r1, r2, r3;
        logic a, b, c;
        r1 = n1;
        r2 = n2;
        r3 = n3;
        while (r1 + r2 + r3 > 0) begin
            a = (r1 > 0) && ($urandom_range(0, 1) == 1);
            b = (r2 > 0) && ($urandom_range(0, 1) == 1);
            c = (r3 > 0) && ($urandom_range(0, 1) == 1);
            if (!a && !b && !c) begin
                if ($urandom_range(0, 1) == 0) drive(0, 0, 0, 0, '0);
                if (r1 > 0) a = 1'b1;
                else if (r2 > 0) b = 1'b1;
                else c = 1'b1;
            end
            drive(a, b, c, 0, '0);
            if (a) r1--;
            if (b) r2--;
            if (c) r3--;
        end
    endtask

    task automatic expect_err(input string tag, input int code);
        check_eq({tag, "_err"}, 32'(err_o), 1);
        check_eq({tag, "_code"}, 32'(err_code_o), 32'(code));
        check_eq({tag, "_busy"}, 32'(busy_o), 0);
        check_eq({tag, "_done"}, 32'(done_o), 0);
    endtask

    // finish a frame from the end of its rows: dense strobe then result two cycles later
    task automatic finish_frame(input logic [3:0] sel, input int sc[NC]);
        int cls;
        cls = ref_argmax(sc);
        exp_q.push_back(3'(cls));
        drive(0, 0, 0, 1, pack(sc));
        check_eq("argmax_done", 32'(done_o), 0);
        check_eq("argmax_busy", 32'(busy_o), 1);
        tick();
        exp_frames++;
        check_eq("done_done", 32'(done_o), 1);
        check_eq("done_busy", 32'(busy_o), 0);
        check_eq("done_err", 32'(err_o), 0);
        check_eq("done_class", 32'(class_o), 32'(exp_q.pop_front()));
        check_eq("done_onehot", 32'(class_onehot_o), 32'(7'd1 << cls));
        check_eq("done_frames", 32'(frame_cnt_o), 32'(exp_frames[15:0]));
        check_eq("done_sel", 32'(img_sel_o), 32'(sel));
    endtask

    task automatic legal_frame(input logic [3:0] sel, input int sc[NC]);
        do_start(sel);
        feed_layers(12, 6, 3);
        check_eq("rows_busy", 32'(busy_o), 1);
        finish_frame(sel, sc);
    endtask

    task automatic rand_scores(output int sc[NC]);
        logic ties;
        ties = ($urandom_range(0, 1) == 1);
        for (int k = 0; k < NC; k++) begin
            if (ties) sc[k] = int'($urandom_range(0, 6)) - 3;
            else      sc[k] = int'($urandom_range(0, 255)) - 128;
        end
    endtask

    task automatic idle_until_timeout(input string tag);
        repeat (TO - 1) tick();
        check_eq({tag, "_pre_err"}, 32'(err_o), 0);
        tick();
        expect_err(tag, 1);
    endtask

    // main sequence
    initial begin
        int sc[NC];
        int nom[NC];
        int cnt;
        int kind;
        int lay;
        logic [2:0] held_class;

        reset = 1'b1;
        start_i = 1'b0;
        sel_i = '0;
        l1_valid_i = 1'b0;
        l2_valid_i = 1'b0;
        l3_valid_i = 1'b0;
        dense_valid_i = 1'b0;
        dense_data_i = '0;
        repeat (3) tick();
        check_eq("rst_busy", 32'(busy_o), 0);
        check_eq("rst_done", 32'(done_o), 0);
        check_eq("rst_err", 32'(err_o), 0);
        check_eq("rst_code", 32'(err_code_o), 0);
        check_eq("rst_class", 32'(class_o), 0);
        check_eq("rst_onehot", 32'(class_onehot_o), 0);
        check_eq("rst_frames", 32'(frame_cnt_o), 0);
        check_eq("rst_sel", 32'(img_sel_o), 0);
        check_eq("rst_img_start", 32'(img_start_o), 0);
        reset = 1'b0;
        tick();

        // nominal frame
        nom = '{3, -2, 9, 9, 0, -128, 1};
        legal_frame(4'd5, nom);
        check_eq("nom_onehot_lit", 32'(class_onehot_o), 32'h04);

        // all-minimum scores, then restart from DONE
        for (int k = 0; k < NC; k++) sc[k] = -128;
        legal_frame(4'd9, sc);
        rand_scores(sc);
        legal_frame(4'd3, sc);

        // inputs ignored in DONE
        held_class = class_o;
        drive(1, 1, 1, 1, NC*DWB'($urandom));
        drive(0, 0, 0, 1, NC*DWB'($urandom));
        check_eq("done_hold", 32'(done_o), 1);
        check_eq("done_hold_class", 32'(class_o), 32'(held_class));
        check_eq("done_hold_frames", 32'(frame_cnt_o), 32'(exp_frames[15:0]));

        // early dense after two layer-3 rows
        do_start(4'd1);
        feed_layers(12, 6, 2);
        drive(0, 0, 0, 1, '0);
        expect_err("early_dense", 2);

        // 13th layer-1 row
        do_start(4'd2);
        feed_layers(12, 0, 0);
        drive(1, 0, 0, 0, '0);
        expect_err("l1_ovf", 3);
        drive(1, 1, 1, 1, '0);
        expect_err("err_hold", 3);

        // timeout with no rows at all
        do_start(4'd4);
        idle_until_timeout("to_entry");

        // overflow outranks dense in the same cycle
        do_start(4'd6);
        feed_layers(12, 6, 3);
        drive(0, 0, 1, 1, '0);
        expect_err("l3_ovf_dense", 3);
        do_start(4'd7);
        feed_layers(12, 0, 1);
        drive(1, 0, 0, 1, '0);
        expect_err("l1_ovf_early", 3);

        // held start: one loader pulse only (frame then times out)
        start_i = 1'b1;
        sel_i = 4'd8;
        cnt = 0;
        repeat (100) begin
            tick();
            if (img_start_o) cnt++;
        end
        check_eq("held_start_pulses", 32'(cnt), 1);
        expect_err("held_start", 1);
        start_i = 1'b0;
        tick();

        // start edge during RUN is ignored
        rand_scores(sc);
        do_start(4'd10);
        feed_layers(5, 2, 1);
        start_i = 1'b1;
        tick();
        check_eq("run_start_img", 32'(img_start_o), 0);
        check_eq("run_start_busy", 32'(busy_o), 1);
        start_i = 1'b0;
        feed_layers(7, 4, 2);
        finish_frame(4'd10, sc);

        // reset mid-frame with seven layer-1 rows
        do_start(4'd11);
        feed_layers(7, 0, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_frames = 0;
        check_eq("midrst_busy", 32'(busy_o), 0);
        check_eq("midrst_done", 32'(done_o), 0);
        check_eq("midrst_err", 32'(err_o), 0);
        check_eq("midrst_sel", 32'(img_sel_o), 0);
        check_eq("midrst_frames", 32'(frame_cnt_o), 0);
        check_eq("midrst_class", 32'(class_o), 0);
        check_eq("midrst_onehot", 32'(class_onehot_o), 0);
        check_eq("midrst_img_start", 32'(img_start_o), 0);
        rand_scores(sc);
        legal_frame(4'd12, sc);

        // randomized frames
        for (int it = 0; it < 24; it++) begin
            kind = int'($urandom_range(0, 5));
            if (kind <= 2) begin
                rand_scores(sc);
                legal_frame(4'($urandom), sc);
            end else if (kind == 3) begin
                do_start(4'($urandom));
                feed_layers(int'($urandom_range(0, 12)), int'($urandom_range(0, 6)),
                            int'($urandom_range(0, 2)));
                drive(0, 0, 0, 1, NC*DWB'($urandom));
                expect_err("rnd_early", 2);
            end else if (kind == 4) begin
                do_start(4'($urandom));
                lay = int'($urandom_range(1, 3));
                feed_layers(lay == 1 ? 12 : int'($urandom_range(0, 11)),
                            lay == 2 ? 6 : int'($urandom_range(0, 5)),
                            lay == 3 ? 3 : int'($urandom_range(0, 2)));
                drive(lay == 1, lay == 2, lay == 3, $urandom_range(0, 1) == 1, '0);
                expect_err("rnd_ovf", 3);
            end else begin
                do_start(4'($urandom));
                feed_layers(int'($urandom_range(0, 12)), int'($urandom_range(0, 6)),
                            int'($urandom_range(0, 3)));
                idle_until_timeout("rnd_to");
            end
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
